// File: rtl/fp8_pkg.sv
// Shared constants and types for the FP8 MAC processing element:
// operand format encodings, exponent biases and BF16 packing constants.
package fp8_pkg;

    localparam logic FMT_E4M3 = 1'b0;
    localparam logic FMT_E5M2 = 1'b1;

    localparam logic [4:0] E4M3_BIAS = 5'd7;
    localparam logic [4:0] E5M2_BIAS = 5'd15;

    localparam logic [7:0]  BF16_BIAS = 8'd127;
    localparam logic [15:0] BF16_ZERO = 16'h0000;

    // Decoded operand: unbiased exponent is two's complement in exp.
    typedef struct packed {
        logic       sign;
        logic       special;
        logic [6:0] exp;
        logic [3:0] man;
    } fp8_dec_t;

endpackage

// File: rtl/acc_to_bf16.sv
// Combinational conversion of a signed fixed-point accumulator value to BF16
// (truncating mantissa): priority leading-one detect, then pack.
module acc_to_bf16
    import fp8_pkg::*;
#(
    parameter int ACC_W     = 18,
    parameter int FRAC_BITS = 8
) (
    input  logic [ACC_W-1:0] res,
    output logic [15:0]      bf16
);

    localparam int IW = $clog2(ACC_W);

    logic [ACC_W-1:0] mag;
    logic [IW-1:0]    lead;
    logic [6:0]       man;

    always_comb begin
        mag  = res[ACC_W-1] ? -res : res;
        lead = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) lead = IW'(i);
        end
    end

    // Mantissa bit k is the bit k+1 places below the leading one, zero past bit 0.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_man
            logic [IW-1:0] idx;
            assign idx = lead - IW'(gi + 1);
            assign man[6-gi] = (lead > IW'(gi)) ? mag[idx] : 1'b0;
        end
    endgenerate

    always_comb begin
        bf16 = {res[ACC_W-1], BF16_BIAS + 8'(lead) - 8'(FRAC_BITS), man};
        if (res == '0) bf16 = BF16_ZERO;
    end

endmodule

// File: rtl/fp8_mac_pe.sv
// Two-stage systolic FP8 (E4M3/E5M2) multiply-accumulate PE with a saturating
// fixed-point accumulator and a double-buffered BF16 result register.
module fp8_mac_pe
    import fp8_pkg::*;
#(
    parameter int ACC_W     = 18,
    parameter int FRAC_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fmt,
    input  logic        in_valid,
    input  logic        clear,
    input  logic        drain,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic [7:0]  a_out,
    output logic [7:0]  b_out,
    output logic        valid_out,
    output logic [15:0] c_out,
    output logic        c_valid,
    output logic        c_ovf
);

    localparam int PW = ACC_W + 8;
    localparam logic [ACC_W-1:0]        MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   SUM_MIN = -SUM_MAX;
    localparam logic signed [8:0]       SH_OFS  = 9'(FRAC_BITS - 6);
    localparam logic signed [8:0]       ACC_W_S = 9'(ACC_W);

    function automatic fp8_dec_t decode(input logic f, input logic [7:0] x);
        fp8_dec_t   d;
        logic [4:0] ef;
        logic [4:0] bias;
        d.sign    = x[7];
        d.special = 1'b0;
        d.man     = '0;
        ef        = '0;
        bias      = E4M3_BIAS;
        case (f)
            FMT_E4M3: begin
                ef        = {1'b0, x[6:3]};
                bias      = E4M3_BIAS;
                d.man     = {|x[6:3], x[2:0]};
                d.special = &x[6:0];
            end
            FMT_E5M2: begin
                ef        = x[6:2];
                bias      = E5M2_BIAS;
                d.man     = {|x[6:2], x[1:0], 1'b0};
                d.special = &x[6:2];
            end
        endcase
        if (ef == 5'd0) ef = 5'd1;
        d.exp = {2'b00, ef} - {2'b00, bias};
        return d;
    endfunction

    fp8_dec_t                da, db;
    logic [7:0]              man_prod;
    logic signed [8:0]       shift;
    logic [8:0]              rshift;
    logic [PW-1:0]           mag_wide;
    logic [ACC_W-1:0]        mag;
    logic                    sat_c;
    logic signed [ACC_W-1:0] prod_c;

    // Stage 1: decode, 4x4 mantissa multiply, align into the accumulator's fixed point.
    always_comb begin
        da       = decode(fmt, a_in);
        db       = decode(fmt, b_in);
        man_prod = {4'b0, da.man} * {4'b0, db.man};
        shift    = $signed({{2{da.exp[6]}}, da.exp}) + $signed({{2{db.exp[6]}}, db.exp}) + SH_OFS;
        rshift   = -shift;
        mag_wide = '0;
        sat_c    = 1'b0;
        if (!shift[8]) begin
            if (shift >= ACC_W_S) sat_c = (man_prod != 8'd0);
            else                  mag_wide = PW'(man_prod) << shift[7:0];
        end else if (rshift < 9'd8) begin
            mag_wide = PW'(man_prod >> rshift[2:0]);
        end
        if (mag_wide > PW'(MAX_POS)) sat_c = 1'b1;
        if (da.special || db.special) sat_c = 1'b1;
        mag    = sat_c ? MAX_POS : mag_wide[ACC_W-1:0];
        prod_c = (da.sign ^ db.sign) ? -$signed(mag) : $signed(mag);
    end

    logic [7:0]              a_reg, b_reg;
    logic signed [ACC_W-1:0] p1_reg;
    logic                    sat1_reg, v1_reg, clr1_reg, drn1_reg;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic                    ovf_reg, ovf_next;
    logic [ACC_W-1:0]        res_reg;
    logic                    c_valid_reg, c_ovf_reg;
    logic signed [ACC_W:0]   sum;

    // Stage 2: symmetric saturating accumulate; snapshot sees this edge's value.
    always_comb begin
        acc_next = acc_reg;
        ovf_next = ovf_reg;
        sum      = $signed({acc_reg[ACC_W-1], acc_reg}) + $signed({p1_reg[ACC_W-1], p1_reg});
        if (v1_reg) begin
            if (clr1_reg) begin
                acc_next = p1_reg;
                ovf_next = sat1_reg;
            end else begin
                ovf_next = ovf_reg | sat1_reg;
                if (sum > SUM_MAX) begin
                    acc_next = $signed(MAX_POS);
                    ovf_next = 1'b1;
                end else if (sum < SUM_MIN) begin
                    acc_next = -$signed(MAX_POS);
                    ovf_next = 1'b1;
                end else begin
                    acc_next = sum[ACC_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            p1_reg      <= '0;
            sat1_reg    <= 1'b0;
            v1_reg      <= 1'b0;
            clr1_reg    <= 1'b0;
            drn1_reg    <= 1'b0;
            acc_reg     <= '0;
            ovf_reg     <= 1'b0;
            res_reg     <= '0;
            c_valid_reg <= 1'b0;
            c_ovf_reg   <= 1'b0;
        end else begin
            a_reg       <= a_in;
            b_reg       <= b_in;
            p1_reg      <= prod_c;
            sat1_reg    <= sat_c;
            v1_reg      <= in_valid;
            clr1_reg    <= clear;
            drn1_reg    <= drain;
            acc_reg     <= acc_next;
            ovf_reg     <= ovf_next;
            c_valid_reg <= drn1_reg;
            if (drn1_reg) begin
                res_reg   <= acc_next;
                c_ovf_reg <= ovf_next;
            end
        end
    end

    assign a_out     = a_reg;
    assign b_out     = b_reg;
    assign valid_out = v1_reg;
    assign c_valid   = c_valid_reg;
    assign c_ovf     = c_ovf_reg;

    acc_to_bf16 #(
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_bf16 (
        .res  (res_reg),
        .bf16 (c_out)
    );

endmodule

// File: tb/tb_fp8_mac_pe.sv
// Self-checking bench for fp8_mac_pe: directed scenarios plus a randomized run
// compared against a real-arithmetic reference model of the PE.
module tb_fp8_mac_pe;

    localparam int    ACC_W     = 18;
    localparam int    FRAC_BITS = 8;
    localparam longint MAXV     = (longint'(1) << (ACC_W - 1)) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fmt = 1'b0;
    logic        in_valid = 1'b0;
    logic        clear = 1'b0;
    logic        drain = 1'b0;
    logic [7:0]  a_in = '0;
    logic [7:0]  b_in = '0;
    logic [7:0]  a_out, b_out;
    logic        valid_out;
    logic [15:0] c_out;
    logic        c_valid;
    logic        c_ovf;

    int total = 0;
    int bad   = 0;

    fp8_mac_pe #(.ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .fmt       (fmt),
        .in_valid  (in_valid),
        .clear     (clear),
        .drain     (drain),
        .a_in      (a_in),
        .b_in      (b_in),
        .a_out     (a_out),
        .b_out     (b_out),
        .valid_out (valid_out),
        .c_out     (c_out),
        .c_valid   (c_valid),
        .c_ovf     (c_ovf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint     m_acc, m_res, s_p;
    bit         m_ovf, m_cov, m_cval, s_v, s_c, s_d, s_sat, m_vout;
    logic [7:0] m_aout, m_bout;

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) repeat (e) r = r * 2.0;
        else        repeat (-e) r = r / 2.0;
        return r;
    endfunction

    function automatic void fp8_val(input logic f, input logic [7:0] x, output real mag, output bit special);
        int ef, fr;
        if (f) begin
            ef = int'(x[6:2]); fr = int'(x[1:0]);
            special = (ef == 31);
            mag = (ef == 0) ? (fr / 4.0) * pow2(-14) : (1.0 + fr / 4.0) * pow2(ef - 15);
        end else begin
            ef = int'(x[6:3]); fr = int'(x[2:0]);
            special = (x[6:0] == 7'h7F);
            mag = (ef == 0) ? (fr / 8.0) * pow2(-6) : (1.0 + fr / 8.0) * pow2(ef - 7);
        end
    endfunction

    function automatic void model_prod(input logic f, input logic [7:0] a, input logic [7:0] b,
                                       output longint p, output bit sat);
        real va, vb, scaled;
        bit  sa, sb;
        longint mag;
        fp8_val(f, a, va, sa);
        fp8_val(f, b, vb, sb);
        scaled = va * vb * pow2(FRAC_BITS);
        if (sa || sb || scaled > real'(MAXV)) begin
            mag = MAXV; sat = 1'b1;
        end else begin
            mag = longint'($floor(scaled)); sat = 1'b0;
        end
        p = (a[7] ^ b[7]) ? -mag : mag;
    endfunction

    function automatic logic [15:0] model_bf16(input longint r);
        longint mag;
        int     p;
        logic [6:0] man;
        logic [7:0] ex;
        if (r == 0) return 16'h0000;
        mag = (r < 0) ? -r : r;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        man = 7'(((mag << 7) >> p) & 127);
        ex  = 8'(127 + p - FRAC_BITS);
        return {r < 0, ex, man};
    endfunction

    task automatic model_reset();
        m_acc = 0; m_res = 0; s_p = 0;
        m_ovf = 0; m_cov = 0; m_cval = 0; s_v = 0; s_c = 0; s_d = 0; s_sat = 0; m_vout = 0;
        m_aout = '0; m_bout = '0;
    endtask

    // Drive one cycle of inputs, advance one clock, and advance the model to match.
    task automatic step(input logic f, input logic v, input logic c, input logic d,
                        input logic [7:0] a, input logic [7:0] b);
        longint p;
        bit     sat;
        fmt = f; in_valid = v; clear = c; drain = d; a_in = a; b_in = b;
        @(posedge clk);
        #1;
        if (s_v) begin
            if (s_c) begin
                m_acc = s_p; m_ovf = s_sat;
            end else begin
                m_acc = m_acc + s_p;
                m_ovf = m_ovf | s_sat;
                if (m_acc > MAXV)       begin m_acc = MAXV;  m_ovf = 1'b1; end
                else if (m_acc < -MAXV) begin m_acc = -MAXV; m_ovf = 1'b1; end
            end
        end
        m_cval = s_d;
        if (s_d) begin m_res = m_acc; m_cov = m_ovf; end
        model_prod(f, a, b, p, sat);
        s_v = v; s_c = c; s_d = d; s_p = p; s_sat = sat;
        m_aout = a; m_bout = b; m_vout = v;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (c_out !== 16'h0000) begin bad++; $display("FAIL reset_c_out: got %h want 0000", c_out); end
        total++; if (c_valid !== 1'b0)   begin bad++; $display("FAIL reset_c_valid: got %b want 0", c_valid); end
        total++; if (c_ovf !== 1'b0)     begin bad++; $display("FAIL reset_c_ovf: got %b want 0", c_ovf); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        total++; if (a_out !== 8'h00 || b_out !== 8'h00) begin bad++; $display("FAIL reset_ab_out: got %h/%h want 00/00", a_out, b_out); end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: c_out=%h c_valid=%b", c_out, c_valid);
    endtask

    task automatic test_unit_product();
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h38, 8'h38);
        total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL unit_early_valid: got %b want 0", c_valid); end
        total++; if (valid_out !== 1'b1 || a_out !== 8'h38 || b_out !== 8'h38) begin bad++; $display("FAIL unit_forward: got v=%b a=%h b=%h want 1/38/38", valid_out, a_out, b_out); end
        idle();
        total++; if (c_valid !== 1'b1)    begin bad++; $display("FAIL unit_c_valid: got %b want 1", c_valid); end
        total++; if (c_out !== 16'h3F80)  begin bad++; $display("FAIL unit_c_out: got %h want 3F80", c_out); end
        total++; if (c_ovf !== 1'b0)      begin bad++; $display("FAIL unit_c_ovf: got %b want 0", c_ovf); end
        idle();
        total++; if (c_valid !== 1'b0 || c_out !== 16'h3F80) begin bad++; $display("FAIL unit_pulse_hold: got v=%b c=%h want 0/3F80", c_valid, c_out); end
        $display("unit: c_out=%h c_ovf=%b", c_out, c_ovf);
    endtask

    task automatic test_accumulate_bubble();
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h38, 8'h40);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h38, 8'h40);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h38, 8'h40);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h38, 8'h40);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h38, 8'h40);
        idle();
        total++; if (c_valid !== 1'b1 || c_out !== 16'h4100) begin bad++; $display("FAIL accum_c_out: got v=%b c=%h want 1/4100", c_valid, c_out); end
        total++; if (c_ovf !== 1'b0) begin bad++; $display("FAIL accum_c_ovf: got %b want 0", c_ovf); end
        $display("accumulate: c_out=%h c_ovf=%b", c_out, c_ovf);
    endtask

    task automatic test_e5m2();
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'hBE);
        idle();
        total++; if (c_valid !== 1'b1 || c_out !== 16'hBFC0) begin bad++; $display("FAIL e5m2_c_out: got v=%b c=%h want 1/BFC0", c_valid, c_out); end
        $display("e5m2: c_out=%h c_ovf=%b", c_out, c_ovf);
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h7E, 8'h7E);
        idle();
        total++; if (c_out !== 16'h43FF) begin bad++; $display("FAIL sat_c_out: got %h want 43FF", c_out); end
        total++; if (c_ovf !== 1'b1)     begin bad++; $display("FAIL sat_c_ovf: got %b want 1", c_ovf); end
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h38, 8'h38);
        idle();
        total++; if (c_out !== 16'h3F80 || c_ovf !== 1'b0) begin bad++; $display("FAIL sat_next_tile: got c=%h ovf=%b want 3F80/0", c_out, c_ovf); end
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h7C, 8'h3C);
        idle();
        total++; if (c_ovf !== 1'b1 || c_out !== 16'h43FF) begin bad++; $display("FAIL sat_special: got c=%h ovf=%b want 43FF/1", c_out, c_ovf); end
        $display("saturation: c_out=%h c_ovf=%b", c_out, c_ovf);
    endtask

    task automatic test_denorm_redrain();
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01);
        idle();
        total++; if (c_valid !== 1'b1 || c_out !== 16'h0000) begin bad++; $display("FAIL denorm_c_out: got v=%b c=%h want 1/0000", c_valid, c_out); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h38, 8'h38);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h7E, 8'h7E);
        idle();
        total++; if (c_valid !== 1'b1 || c_out !== 16'h3F80) begin bad++; $display("FAIL redrain_c_out: got v=%b c=%h want 1/3F80", c_valid, c_out); end
        $display("denorm/redrain: c_out=%h", c_out);
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h38, 8'h38);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h38, 8'h38);
        total++; if (c_valid !== 1'b1 || c_out !== 16'h3F80) begin bad++; $display("FAIL b2b_first: got v=%b c=%h want 1/3F80", c_valid, c_out); end
        idle();
        total++; if (c_valid !== 1'b1 || c_out !== 16'h4000) begin bad++; $display("FAIL b2b_second: got v=%b c=%h want 1/4000", c_valid, c_out); end
        idle();
        total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse_end: got %b want 0", c_valid); end
        $display("back_to_back: c_out=%h", c_out);
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h38, 8'h38);
        rst = 1'b1;
        #2;
        total++; if (c_out !== 16'h0000 || c_ovf !== 1'b0) begin bad++; $display("FAIL arst_c_out: got c=%h ovf=%b want 0000/0", c_out, c_ovf); end
        total++; if (valid_out !== 1'b0 || a_out !== 8'h00 || b_out !== 8'h00) begin bad++; $display("FAIL arst_forward: got v=%b a=%h b=%h want 0/00/00", valid_out, a_out, b_out); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h38, 8'h40);
        idle();
        total++; if (c_valid !== 1'b1 || c_out !== 16'h4000) begin bad++; $display("FAIL arst_clean_tile: got v=%b c=%h want 1/4000", c_valid, c_out); end
        $display("async_reset: c_out=%h", c_out);
    endtask

    function automatic logic [7:0] rand_op(input logic f);
        logic [7:0] x;
        x = 8'($urandom);
        // Mostly keep exponents near the bias so tiles accumulate meaningful sums.
        if ($urandom_range(0, 3) != 0) begin
            if (f) x[6:2] = 5'($urandom_range(11, 17));
            else   x[6:3] = 4'($urandom_range(4, 9));
        end
        return x;
    endfunction

    task automatic test_random();
        logic f, v, c, d;
        logic [15:0] exp_c;
        for (int i = 0; i < 300; i++) begin
            f = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 3) != 0);
            c = (i == 0) || ($urandom_range(0, 7) == 0);
            d = ($urandom_range(0, 3) == 0);
            step(f, v, c, d, rand_op(f), rand_op(f));
            exp_c = model_bf16(m_res);
            total++; if (valid_out !== m_vout) begin bad++; $display("FAIL rnd_valid_out[%0d]: got %b want %b", i, valid_out, m_vout); end
            total++; if (a_out !== m_aout || b_out !== m_bout) begin bad++; $display("FAIL rnd_ab_out[%0d]: got %h/%h want %h/%h", i, a_out, b_out, m_aout, m_bout); end
            total++; if (c_valid !== m_cval) begin bad++; $display("FAIL rnd_c_valid[%0d]: got %b want %b", i, c_valid, m_cval); end
            total++; if (c_out !== exp_c)    begin bad++; $display("FAIL rnd_c_out[%0d]: got %h want %h", i, c_out, exp_c); end
            total++; if (c_ovf !== m_cov)    begin bad++; $display("FAIL rnd_c_ovf[%0d]: got %b want %b", i, c_ovf, m_cov); end
            if (m_cval) $display("rnd[%0d]: drain c_out=%h c_ovf=%b (acc=%0d)", i, c_out, c_ovf, m_res);
        end
    endtask

    initial begin
        test_reset();
        test_unit_product();
        test_accumulate_bubble();
        test_e5m2();
        test_saturation();
        test_denorm_redrain();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp8_mac_pe.md
# fp8_mac_pe

Parametrised two-stage systolic FP8 multiply-accumulate processing element, and the next generation of the array PE. Each operand pair can be E4M3 or E5M2, selected at run time. Products accumulate in a saturating fixed-point register of configurable width. A drain snapshot is double-buffered into a result register and presented as BF16 while the next tile keeps accumulating. Tiles into the systolic array like the current PE: operands and valid are forwarded east/south.

## Interface
- ACC_W, 18: accumulator width in bits, two's complement, 12..32.
- FRAC_BITS, 8: fractional bits of the fixed-point accumulator, must be < ACC_W-1.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fmt  in  1  operand format, sampled with the operands: 0 = E4M3 (bias 7), 1 = E5M2 (bias 15).
- in_valid  in  1  a_in/b_in carry a real sample this cycle.
- clear  in  1  with in_valid: this product starts a new tile (acc loads product instead of adding).
- drain  in  1  snapshot the accumulator after this cycle's product (in_valid may be 0).
- a_in  in  8  FP8 operand A.
- b_in  in  8  FP8 operand B.
- a_out  out  8  a_in delayed 1 cycle.
- b_out  out  8  b_in delayed 1 cycle.
- valid_out  out  1  in_valid delayed 1 cycle.
- c_out  out  16  BF16 of the result register; holds until the next drain.
- c_valid  out  1  one-cycle pulse when the result register is updated.
- c_ovf  out  1  saturation flag for the tile in c_out.

## Operation
- Decode E4M3: sign = [7], exp = [6:3], mantissa m = {hidden, [2:0]}.
- Decode E5M2: sign = [7], exp = [6:2], m = {hidden, [1:0], 1'b0}.
- hidden = (exp != 0). The unbiased exponent is e = (exp==0 ? 1 : exp) - bias.
- Specials: E4M3 S.1111.111 and E5M2 exp = 11111 are NaN/Inf.
  - Any special operand forces the product to ±max magnitude and sets the saturation flag for that product.
- The 4x4 mantissa product is 8 bits with 6 fraction bits.
  - Alignment shift = ea + eb - 6 + FRAC_BITS. Shift left if positive, right if negative (truncate toward zero).
  - A right shift ≥ 8 gives 0.
  - A result with magnitude > 2^(ACC_W-1)-1 clamps to 2^(ACC_W-1)-1 and sets the product saturation flag.
  - Negate if signA^signB.
- Stage 1 registers: signed product P1, sat1, v1, clr1, drn1.
- Stage 2 accumulate, when v1:
  - clr1: acc = P1, ovf = sat1.
  - otherwise: acc = sat(acc+P1), ovf |= sat1 | add overflow.
  - sat clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)-1), symmetric.
- When v1 = 0, acc and ovf hold; clr1 without v1 is ignored.
- When drn1 is set: res <= the acc value being written this edge (held acc if !v1), c_ovf <= the matching ovf, c_valid <= 1. Otherwise c_valid <= 0.
- clear and drain in the same cycle: the snapshot equals that single product.
- BF16 conversion is combinational from res:
  - res = 0 gives 0x0000.
  - Otherwise: sign, magnitude, leading-one position p, exponent = 127 + p - FRAC_BITS, mantissa = the next 7 bits below p, truncated and zero-filled.

## Timing
- a_out, b_out, valid_out: latency 1.
- Operands presented at cycle t accumulate at edge t+1.
- A drain issued at cycle t makes c_out/c_valid visible in cycle t+2.
- Throughput is one product per cycle with no stalls; back-to-back drains are legal.
- Reset (asynchronous, any time): all registers go to 0, so a_out = b_out = 0, valid_out = c_valid = c_ovf = 0, c_out = 0x0000. In-flight stage-1 samples are discarded.
- Deasserting rst mid-tile: the next tile must begin with clear.

## Structure
- Shared package fp8_pkg:
  - fmt encodings (FMT_E4M3 = 0, FMT_E5M2 = 1) and the biases 7 and 15.
  - BF16 bias 127 and the BF16 zero constant.
- Sub-module acc_to_bf16 (parameters ACC_W, FRAC_BITS): combinational priority LZD plus pack. Instantiated once on res.
- Decode, multiply and align live inline in stage 1.

## Test plan
- E4M3 0x38 × 0x38 with in_valid + clear + drain in one cycle -> c_out = 0x3F80, c_valid pulse at t+2, c_ovf = 0.
- Four cycles of 0x38 × 0x40: clear on the first, drain on the fourth, plus one in_valid = 0 bubble mid-stream -> c_out = 0x4100 (8.0).
- fmt = 1, E5M2 0x3C × 0xBE (1.0 × -1.5) with clear + drain -> c_out = 0xBFC0.
- Default params, E4M3 0x7E × 0x7E (448²) with clear + drain -> c_out = 0x43FF, c_ovf = 1. The next tile with clear on 0x38 × 0x38 -> c_ovf = 0.
- Denorm E4M3 0x01 × 0x01 (2^-18) -> product truncates to 0, c_out = 0x0000. Drain with in_valid = 0 re-snapshots the held acc.
- rst asserted between clear and drain -> all outputs 0 asynchronously. The following clean tile of 0x38 × 0x40 -> c_out = 0x4000.
